// File: rtl/motor_speed_ramp.sv
// Soft-start/soft-stop speed command stage feeding the motor PWM generator.
// Optional MOTOR_RAMP_DIR_EN adds dir_req/dir with a forced ramp to zero on direction change.
module motor_speed_ramp #(
  parameter int unsigned ARM_TICKS  = 1000,
  parameter int unsigned UP_TICKS   = 1000000,
  parameter int unsigned DOWN_TICKS = 500000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] target,
  input  logic       enable,
  input  logic       estop,
`ifdef MOTOR_RAMP_DIR_EN
  input  logic       dir_req,
  output logic       dir,
`endif
  output logic [3:0] speed,
  output logic       activate,
  output logic       at_target,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_UP    = 3'd2,
    S_HOLD  = 3'd3,
    S_DOWN  = 3'd4,
    S_STOP  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(UP_TICKS - 1);
  localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(DOWN_TICKS - 1);

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic [3:0]       spd_d;
  logic             act_d, fire, force_dir;
  logic             dir_q, dir_d, dir_in;

`ifdef MOTOR_RAMP_DIR_EN
  assign dir_in = dir_req;
  assign dir    = dir_q;
`else
  assign dir_in = 1'b0;
`endif

  // A direction mismatch while driving forces a ramp to zero before re-arming.
  assign force_dir = activate && (dir_in != dir_q);
  assign fire      = (cnt_q >= last);
  assign state     = st_q;

  always_comb begin
    case (st_q)
      S_ARM:   last = ARM_LAST;
      S_UP:    last = UP_LAST;
      default: last = DOWN_LAST;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    spd_d = speed;
    act_d = activate;
    dir_d = dir_q;
    case (st_q)
      S_IDLE: begin
        spd_d = '0;
        act_d = 1'b0;
        dir_d = dir_in;
        if (enable) begin
          st_d  = S_ARM;
          act_d = 1'b1;
        end
      end
      S_ARM: begin
        spd_d = '0;
        act_d = 1'b1;
        if (!enable) st_d = S_STOP;
        else if (fire) begin
          dir_d = dir_in;
          st_d  = (target != 4'd0) ? S_UP : S_HOLD;
        end
      end
      S_UP: begin
        if (!enable) st_d = S_STOP;
        else if (force_dir) st_d = (speed == 4'd0) ? S_ARM : S_DOWN;
        else if (target < speed) st_d = S_DOWN;
        else if (target == speed) st_d = S_HOLD;
        else if (fire) begin
          spd_d = speed + 4'd1;
          if ((speed + 4'd1) == target) st_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!enable) st_d = S_STOP;
        else if (force_dir) st_d = (speed == 4'd0) ? S_ARM : S_DOWN;
        else if (target > speed) st_d = S_UP;
        else if (target < speed) st_d = S_DOWN;
      end
      S_DOWN: begin
        if (!enable) st_d = S_STOP;
        else if (force_dir) begin
          if (speed == 4'd0) st_d = S_ARM;
          else if (fire) begin
            spd_d = speed - 4'd1;
            if (speed == 4'd1) st_d = S_ARM;
          end
        end
        else if (target > speed) st_d = S_UP;
        else if (target == speed) st_d = S_HOLD;
        else if (fire) begin
          spd_d = speed - 4'd1;
          if ((speed - 4'd1) == target) st_d = S_HOLD;
        end
      end
      S_STOP: begin
        if (speed == 4'd0) st_d = S_IDLE;
        else if (fire) spd_d = speed - 4'd1;
      end
      S_FAULT: begin
        spd_d = '0;
        act_d = 1'b0;
        if (!enable) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    // Activate drops on the very cycle the stop ramp lands on zero.
    if (st_d == S_STOP && spd_d == 4'd0) act_d = 1'b0;

    if (estop) begin
      st_d  = S_FAULT;
      spd_d = '0;
      act_d = 1'b0;
    end

    if (st_d != st_q) cnt_d = '0;
    else if (st_q == S_ARM || st_q == S_UP || st_q == S_DOWN || st_q == S_STOP)
      cnt_d = fire ? '0 : cnt_q + CNT_W'(1);
    else cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      speed     <= '0;
      activate  <= 1'b0;
      at_target <= 1'b0;
      fault     <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      speed     <= spd_d;
      activate  <= act_d;
      at_target <= (st_d == S_HOLD);
      fault     <= (st_d == S_FAULT);
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Self-checking bench for motor_speed_ramp: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_motor_speed_ramp;
  localparam int ARM = 3, UP = 4, DN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] target = 4'd15;
  logic       enable = 1'b1;
  logic       estop = 1'b0;
  logic [3:0] speed;
  logic       activate, at_target, fault;
  logic [2:0] state;
`ifdef MOTOR_RAMP_DIR_EN
  logic       dir_req = 1'b0;
  logic       dir;
`endif

  int checks = 0;
  int errors = 0;

  motor_speed_ramp #(.ARM_TICKS(ARM), .UP_TICKS(UP), .DOWN_TICKS(DN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .target(target), .enable(enable), .estop(estop),
`ifdef MOTOR_RAMP_DIR_EN
    .dir_req(dir_req), .dir(dir),
`endif
    .speed(speed), .activate(activate), .at_target(at_target), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural model: state number, speed and elapsed cycles toward the next step.
  int m_state = 0, m_speed = 0, m_elapsed = 0;

  task automatic enter(input int s);
    m_state   = s;
    m_elapsed = 0;
  endtask

  function automatic int period(input int s);
    if (s == 1) return ARM;
    if (s == 2) return UP;
    return DN;
  endfunction

  always @(posedge clk) begin
    int want_dir;
    bit step;
    step = 1'b0;
    if (m_state == 1 || m_state == 2 || m_state == 4 || m_state == 5) begin
      m_elapsed++;
      if (m_elapsed >= period(m_state)) begin
        step = 1'b1;
        m_elapsed = 0;
      end
    end
    if (rst) begin
      enter(0);
      m_speed = 0;
    end else if (estop) begin
      enter(6);
      m_speed = 0;
    end else begin
      case (m_state)
        0: if (enable) enter(1);
        1: if (!enable) enter(5); else if (step) enter(int'(target) > 0 ? 2 : 3);
        2, 3, 4: begin
          if (!enable) enter(5);
          else if (int'(target) == m_speed) begin
            if (m_state != 3) enter(3);
          end else begin
            want_dir = (int'(target) > m_speed) ? 2 : 4;
            if (want_dir != m_state) enter(want_dir);
            else if (step) begin
              m_speed += (want_dir == 2) ? 1 : -1;
              if (m_speed == int'(target)) enter(3);
            end
          end
        end
        5: if (m_speed == 0) enter(0); else if (step) m_speed--;
        6: if (!enable) enter(0);
        default: enter(0);
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int m_act;
    m_act = ((m_state >= 1 && m_state <= 4) || (m_state == 5 && m_speed > 0)) ? 1 : 0;
    chk("model_state", int'(state), m_state);
    chk("model_speed", int'(speed), m_speed);
    chk("model_activate", int'(activate), m_act);
    chk("model_at_target", int'(at_target), (m_state == 3) ? 1 : 0);
    chk("model_fault", int'(fault), (m_state == 6) ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string name, input int st, input int spd, input int budget);
    int n;
    n = 0;
    while (!(int'(state) == st && int'(speed) == spd) && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, (int'(state) == st && int'(speed) == spd) ? 1 : 0, 1);
  endtask

  initial begin
    // Reset held for two edges with enable and a full-scale target present.
    cyc(1);
    chk("rst1_state", int'(state), 0); chk("rst1_speed", int'(speed), 0); chk("rst1_act", int'(activate), 0);
    cyc(1);
    chk("rst2_state", int'(state), 0); chk("rst2_act", int'(activate), 0);
    rst = 1'b0;
    cyc(1);
    chk("arm_after_rst", int'(state), 1);

    // Ramp to 3 from ARM entry.
    rst = 1'b1; cyc(1);
    rst = 1'b0; target = 4'd3;
    cyc(1);
    chk("arm_act", int'(activate), 1); chk("arm_speed", int'(speed), 0);
    cyc(6);
    chk("up_pre_step", int'(speed), 0); chk("up_entered", int'(state), 2);
    cyc(1); chk("up_speed1", int'(speed), 1);
    cyc(4); chk("up_speed2", int'(speed), 2);
    cyc(4); chk("up_speed3", int'(speed), 3);
    chk("hold_state", int'(state), 3); chk("hold_at_target", int'(at_target), 1);

    // Ramp down 3 -> 1.
    target = 4'd1;
    cyc(1); chk("down_entry_state", int'(state), 4); chk("down_entry_speed", int'(speed), 3);
    cyc(2); chk("down_speed2", int'(speed), 2);
    cyc(2); chk("down_speed1", int'(speed), 1); chk("down_hold", int'(state), 3);

    // Up to 15 (saturation), then controlled stop.
    target = 4'd15;
    cyc(1);
    wait_for("reach_15", 3, 15, 80);
    enable = 1'b0;
    cyc(1); chk("stop_entry", int'(state), 5); chk("stop_speed15", int'(speed), 15);
    enable = 1'b1;  // must be ignored until IDLE
    cyc(29); chk("stop_speed1", int'(speed), 1); chk("stop_act_hi", int'(activate), 1);
    cyc(1); chk("stop_speed0", int'(speed), 0); chk("stop_act_lo", int'(activate), 0);
    chk("stop_still", int'(state), 5);
    enable = 1'b0;
    cyc(1); chk("stop_idle", int'(state), 0);

    // Emergency stop mid-ramp and latched fault.
    enable = 1'b1; target = 4'd10;
    wait_for("reach_6", 2, 6, 60);
    estop = 1'b1;
    cyc(1);
    chk("estop_speed", int'(speed), 0); chk("estop_act", int'(activate), 0);
    chk("estop_fault", int'(fault), 1); chk("estop_state", int'(state), 6);
    estop = 1'b0;
    cyc(3); chk("fault_latched", int'(state), 6); chk("fault_flag", int'(fault), 1);
    enable = 1'b0;
    cyc(1); chk("fault_exit", int'(state), 0); chk("fault_clear", int'(fault), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      if (estop) estop = ($urandom_range(0, 3) != 0);
      else       estop = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 24) == 0) target = 4'($urandom_range(0, 15));
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_speed_ramp.md
Name: motor_speed_ramp

Overview:
- Soft-start/soft-stop command stage placed directly upstream of the motor PWM generator.
- Takes a raw 4-bit speed target from switches/buttons plus enable and emergency-stop, and produces the 4-bit speed code and activate signal the PWM stage consumes.
- Limits speed slew to one code per programmable interval, and handles arming, controlled stop and latched fault.

Parameters:
- ARM_TICKS, 1000, cycles activate is held high at speed 0 before ramping starts (>=1)
- UP_TICKS, 1000000, cycles per +1 speed step (>=1)
- DOWN_TICKS, 500000, cycles per -1 speed step (>=1)
- CNT_W, 24, tick counter width; every *_TICKS value must fit in it

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- target  in  4  requested speed code 0..15, sampled every cycle
- enable  in  1  run request, level-sensitive
- estop  in  1  emergency stop, level-sensitive, highest priority
- speed  out  4  registered speed code to the PWM stage
- activate  out  1  registered activate to the PWM stage
- at_target  out  1  high when in HOLD (speed==target)
- fault  out  1  high while in FAULT
- state  out  3  current state: IDLE=0, ARM=1, RAMP_UP=2, HOLD=3, RAMP_DOWN=4, STOP=5, FAULT=6

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- All outputs are registered. On the first clk edge with rst=1: state=IDLE, speed=0, activate=0, at_target=0, fault=0, counter=0. This applies equally to reset mid-ramp.
- Priority per cycle: rst > estop > enable-low > target tracking.
- Tick counter: cleared on every state entry. In ARM, RAMP_UP, RAMP_DOWN and STOP it increments each cycle. When it reaches N-1 (N = the state's *_TICKS), the step action fires and the counter returns to 0.
- IDLE: speed=0, activate=0. If enable=1 and estop=0, go to ARM next cycle.
- ARM: activate=1, speed=0. After ARM_TICKS cycles in ARM: go to RAMP_UP if target>0, else HOLD.
- RAMP_UP: on each step, speed+1. If the new speed equals target, go to HOLD. If target drops below speed mid-ramp, go to RAMP_DOWN next cycle with the counter restarted. If target moves but stays above speed, keep the counter running.
- HOLD: speed unchanged, at_target=1. On target>speed go to RAMP_UP; on target<speed go to RAMP_DOWN.
- RAMP_DOWN: on each step, speed-1. Equality with target goes to HOLD; a reversal goes to RAMP_UP, mirroring RAMP_UP.
- STOP: entered from any of ARM, RAMP_UP, HOLD or RAMP_DOWN when enable=0.
  - Steps speed down at DOWN_TICKS per code, ignoring target.
  - At the cycle speed reaches 0, activate=0 and the next state is IDLE.
  - Re-asserting enable during STOP has no effect until IDLE is reached.
  - If STOP is entered with speed=0, go to IDLE next cycle.
- FAULT: estop=1 in any state gives state=FAULT, speed=0, activate=0, fault=1 at the next edge, with no ramp. Exit to IDLE only when estop=0 and enable=0 in the same cycle, so a stuck enable cannot auto-restart.
- Speed saturates at 0..15 and never wraps. A step that would go past target is never taken, because equality is checked before each step.
- Any counter value >= N-1 counts as a step.

Optional Feature:
- Macro: MOTOR_RAMP_DIR_EN
- Defined:
  - Adds input dir_req (1 bit) and output dir (1 bit, reset 0).
  - A dir_req change while activate=1 forces a ramp to speed 0 at DOWN_TICKS, ignoring target.
  - Once speed is 0, the block holds speed=0/activate=1 for ARM_TICKS, then updates dir to dir_req, then resumes normal target tracking.
  - state reports RAMP_DOWN during the forced ramp and ARM during the wait.
  - In IDLE, dir follows dir_req directly.
- Undefined: neither port exists, and behaviour is exactly as above.

Test Plan (ARM_TICKS=3, UP_TICKS=4, DOWN_TICKS=2):
- rst=1 for 2 cycles with target=15, enable=1 -> speed=0, activate=0, state=0 throughout; IDLE->ARM on the first cycle after rst falls.
- enable=1, target=3 from IDLE -> activate=1 one cycle later; speed=1,2,3 at 3+4, 3+8, 3+12 cycles after ARM entry; at_target=1 with state=3 after that.
- In HOLD at speed=3, target->1 -> speed=2 two cycles after RAMP_DOWN entry, speed=1 two cycles after that, then HOLD; counter restarts on entry.
- At speed=15 in HOLD, enable->0 -> 15 steps down at 2 cycles each; activate falls on the cycle speed hits 0; state=IDLE next cycle.
- Mid-RAMP_UP at speed=6, estop=1 -> next edge speed=0, activate=0, fault=1. With estop=0 but enable=1, the block stays in FAULT. Setting enable=0 gives IDLE the next cycle.
- MOTOR_RAMP_DIR_EN: at speed=4 with dir=0, toggle dir_req -> ramp to 0 in 8 cycles, activate held for 3 cycles, dir=1, then ramp back to target.
